// File: rtl/sample_iterator.sv
// Walks every grid-aligned sample position of a triangle's bounding box in raster order.
// Optional per-triangle sample index output enabled by defining SAMPLE_ITER_COUNT_EN.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]             box_R13S,
    input  logic                                         validTri_R13H,
    input  logic        [3:0]                            subSample_RnnnnU,
    output logic                                         halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]           color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                  sample_R14S,
    output logic                                         validSamp_R14H
`ifdef SAMPLE_ITER_COUNT_EN
    ,
    output logic        [31:0]                           sampCount_R14U
`endif
);

    typedef enum logic {WAIT_STATE, TEST_STATE} state_t;

    state_t                                       r_state;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
    logic        [COLORS-1:0][SIGFIG-1:0]          r_color;
    logic signed [1:0][1:0][SIGFIG-1:0]            r_box;
    logic signed [1:0][SIGFIG-1:0]                 r_sample;
    logic                                         r_valid;

    logic signed [SIGFIG-1:0] w_x, w_y, w_llx, w_urx, w_ury;
    logic signed [SIGFIG-1:0] w_step;
    logic [1:0]               w_lg2;
    logic                     w_at_last, w_accept, w_nonempty;

    assign w_x   = r_sample[0];
    assign w_y   = r_sample[1];
    assign w_llx = r_box[0][0];
    assign w_urx = r_box[1][0];
    assign w_ury = r_box[1][1];

    always_comb begin
        w_lg2 = 2'd3;
        if (subSample_RnnnnU[3])      w_lg2 = 2'd0;
        else if (subSample_RnnnnU[2]) w_lg2 = 2'd1;
        else if (subSample_RnnnnU[1]) w_lg2 = 2'd2;
        w_step = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(w_lg2));
    end

    assign w_at_last  = (w_x == w_urx) && (w_y == w_ury);
    assign halt_RnnnnL = (r_state == WAIT_STATE) || w_at_last;
    assign w_accept   = validTri_R13H && halt_RnnnnL;
    assign w_nonempty = ($signed(box_R13S[1][0]) >= $signed(box_R13S[0][0])) &&
                        ($signed(box_R13S[1][1]) >= $signed(box_R13S[0][1]));

`ifdef SAMPLE_ITER_COUNT_EN
    logic [31:0] r_count;
    assign sampCount_R14U = r_count;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= WAIT_STATE;
            r_tri    <= '0;
            r_color  <= '0;
            r_box    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
`ifdef SAMPLE_ITER_COUNT_EN
            r_count  <= '0;
`endif
        end else if (w_accept && w_nonempty) begin
            r_tri      <= tri_R13S;
            r_color    <= color_R13U;
            r_box      <= box_R13S;
            r_sample   <= box_R13S[0];
            r_valid    <= 1'b1;
            r_state    <= TEST_STATE;
`ifdef SAMPLE_ITER_COUNT_EN
            r_count    <= 32'd1;
`endif
        end else if (!w_accept && r_state == TEST_STATE && !w_at_last) begin
            // Box corners are grid-aligned upstream, so x lands exactly on ur.x.
            if (w_x < w_urx) begin
                r_sample[0] <= w_x + w_step;
            end else begin
                r_sample[0] <= w_llx;
                r_sample[1] <= w_y + w_step;
            end
`ifdef SAMPLE_ITER_COUNT_EN
            r_count <= r_count + 32'd1;
`endif
        end else begin
            // Idle, end of walk, or an empty box consumed and dropped.
            r_state <= WAIT_STATE;
            r_valid <= 1'b0;
`ifdef SAMPLE_ITER_COUNT_EN
            r_count <= '0;
`endif
        end
    end

    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = r_sample;
    assign validSamp_R14H = r_valid;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: raster walk, rates, back-to-back, degenerate boxes, reset.
module tb_sample_iterator;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic clk = 1'b0;
    logic rst;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                         validTri_R13H;
    logic        [3:0]                            subSample_RnnnnU;
    logic                                         halt_RnnnnL;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic signed [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                         validSamp_R14H;
`ifdef SAMPLE_ITER_COUNT_EN
    logic [31:0] sampCount_R14U;
`endif

    int n_chk = 0;
    int n_err = 0;

    sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
        .clk(clk), .rst(rst),
        .tri_R13S(tri_R13S), .color_R13U(color_R13U), .box_R13S(box_R13S),
        .validTri_R13H(validTri_R13H), .subSample_RnnnnU(subSample_RnnnnU),
        .halt_RnnnnL(halt_RnnnnL), .tri_R14S(tri_R14S), .color_R14U(color_R14U),
        .sample_R14S(sample_R14S), .validSamp_R14H(validSamp_R14H)
`ifdef SAMPLE_ITER_COUNT_EN
        , .sampCount_R14U(sampCount_R14U)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury);
        box_R13S[0][0] = SIGFIG'(llx);
        box_R13S[0][1] = SIGFIG'(lly);
        box_R13S[1][0] = SIGFIG'(urx);
        box_R13S[1][1] = SIGFIG'(ury);
    endtask

    task automatic set_tri(input int base);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = SIGFIG'(base + v * AXIS + a);
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = SIGFIG'(base + 100 + c);
    endtask

    task automatic chk_samp(input string tag, input int x, input int y, input bit v, input bit h);
        chk({tag, ".x"}, 64'(sample_R14S[0]), 64'(x));
        chk({tag, ".y"}, 64'(sample_R14S[1]), 64'(y));
        chk({tag, ".vld"}, 64'(validSamp_R14H), 64'(v));
        chk({tag, ".halt"}, 64'(halt_RnnnnL), 64'(h));
    endtask

    int ex1 [6] = '{0, 1024, 2048, 0, 1024, 2048};
    int ey1 [6] = '{0, 0, 0, 1024, 1024, 1024};

    initial begin
        rst = 1'b1;
        validTri_R13H = 1'b0;
        subSample_RnnnnU = 4'b1000;
        set_tri(0);
        set_box(0, 0, 0, 0);
        repeat (2) tick();
        chk_samp("reset", 0, 0, 1'b0, 1'b1);
        chk("reset.tri", 64'(tri_R14S[2][2]), 64'd0);
        chk("reset.color", 64'(color_R14U[0]), 64'd0);
`ifdef SAMPLE_ITER_COUNT_EN
        chk("reset.cnt", 64'(sampCount_R14U), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // 1 spp, 3x2 walk
        set_tri(10);
        set_box(0, 0, 2048, 1024);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk("t1.tri", 64'(tri_R14S[1][2]), 64'd15);
        chk("t1.color", 64'(color_R14U[2]), 64'd112);
        for (int i = 0; i < 6; i++) begin
            chk_samp($sformatf("t1.s%0d", i), ex1[i], ey1[i], 1'b1, i == 5);
`ifdef SAMPLE_ITER_COUNT_EN
            chk($sformatf("t1.cnt%0d", i), 64'(sampCount_R14U), 64'(i + 1));
`endif
            tick();
        end
        chk_samp("t1.end", 2048, 1024, 1'b0, 1'b1);
`ifdef SAMPLE_ITER_COUNT_EN
        chk("t1.cnt_end", 64'(sampCount_R14U), 64'd0);
`endif

        // 64 spp, two samples
        subSample_RnnnnU = 4'b0001;
        set_box(1024, 1024, 1152, 1024);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("t2.s0", 1024, 1024, 1'b1, 1'b0);
        tick();
        chk_samp("t2.s1", 1152, 1024, 1'b1, 1'b1);
        tick();
        chk("t2.end", 64'(validSamp_R14H), 64'd0);

        // back-to-back A then B
        set_tri(200);
        set_box(0, 0, 128, 0);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("t3.a0", 0, 0, 1'b1, 1'b0);
        chk("t3.a_tri", 64'(tri_R14S[0][0]), 64'd200);
        tick();
        chk_samp("t3.a1", 128, 0, 1'b1, 1'b1);
        set_tri(300);
        set_box(256, 256, 384, 256);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("t3.b0", 256, 256, 1'b1, 1'b0);
        chk("t3.b_tri", 64'(tri_R14S[0][0]), 64'd300);
`ifdef SAMPLE_ITER_COUNT_EN
        chk("t3.b_cnt", 64'(sampCount_R14U), 64'd1);
`endif
        tick();
        chk_samp("t3.b1", 384, 256, 1'b1, 1'b1);
        tick();
        chk("t3.end", 64'(validSamp_R14H), 64'd0);

        // single-sample box
        set_box(512, 512, 512, 512);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("t4.s0", 512, 512, 1'b1, 1'b1);
        tick();
        chk_samp("t4.end", 512, 512, 1'b0, 1'b1);

        // empty box: dropped, no samples
        set_box(1024, 0, 0, 0);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("t5.e0", 512, 512, 1'b0, 1'b1);
        tick();
        chk_samp("t5.e1", 512, 512, 1'b0, 1'b1);

        // reset after 3rd sample of a 4x4 walk
        set_box(0, 0, 384, 384);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        tick();
        tick();
        chk_samp("t6.s2", 256, 0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_samp("t6.rst", 0, 0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t6.idle%0d", i), 64'(validSamp_R14H), 64'd0);
        end
        set_box(640, 640, 640, 640);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("t6.new", 640, 640, 1'b1, 1'b1);
        tick();
        chk("t6.new_end", 64'(validSamp_R14H), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Rasterizer stage between bounding-box generation (R13) and the sample test (R14 onward). Its output feeds the sample test that produces hit_R18S/hit_valid_R18H, which the sample-count scoreboard checks.
- Accepts one triangle plus its sample-grid-aligned bounding box.
- Walks every sample position in the box in raster order, one per cycle.
- Stalls upstream with an active-low halt while the walk is in progress.

Parameters:
- SIGFIG, 24, bits in color and position
- RADIX, 10, fraction bits in position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tri_R13S  in  signed SIGFIG x[VERTS][AXIS]  triangle vertices
- color_R13U  in  SIGFIG x[COLORS]  triangle color
- box_R13S  in  signed SIGFIG x[2][2]  [0]=lower-left, [1]=upper-right; [n][0]=x, [n][1]=y
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot: [3]=1 spp, [2]=4, [1]=16, [0]=64
- halt_RnnnnL  out  1  0 = upstream must hold R13 inputs
- tri_R14S  out  signed SIGFIG x[VERTS][AXIS]  latched triangle
- color_R14U  out  SIGFIG x[COLORS]  latched color
- sample_R14S  out  signed SIGFIG x[2]  current sample (x,y)
- validSamp_R14H  out  1  sample_R14S is valid

Behaviour:
- ss_w_lg2 is 0, 1, 2 or 3 for subSample_RnnnnU bit 3, 2, 1 or 0.
- step = 1 << (RADIX − ss_w_lg2).
- subSample_RnnnnU is static while any triangle is in flight.
- States: WAIT_STATE, TEST_STATE. Reset enters WAIT_STATE.
- Reset values: all outputs 0 except halt_RnnnnL = 1.
- at_last = (sample_R14S[0] == box_ur.x) && (sample_R14S[1] == box_ur.y), using the latched box.
- halt_RnnnnL (combinational) = (state == WAIT_STATE) || (state == TEST_STATE && at_last).
- Accept: on a clock edge with validTri_R13H && halt_RnnnnL, and the box is non-empty (ur.x ≥ ll.x and ur.y ≥ ll.y, signed):
  - register tri, color and box
  - sample_R14S ← ll; validSamp_R14H ← 1
  - state ← TEST_STATE
- Latency: first sample appears one cycle after the accept edge.
- Empty box (ur < ll on either axis): the triangle is consumed and dropped. No samples. Next state is WAIT_STATE.
- TEST_STATE, each edge:
  - If not at_last:
    - x < ur.x: x ← x + step
    - otherwise: x ← ll.x, y ← y + step
    - validSamp_R14H stays 1
  - If at_last:
    - accept a new triangle in the same cycle if offered (back-to-back, no bubble)
    - otherwise validSamp_R14H ← 0 and state ← WAIT_STATE
- WAIT_STATE without a valid triangle: validSamp_R14H ← 0. sample/tri/color hold their last values.
- Arithmetic is SIGFIG-bit signed. Box corners are grid-aligned by upstream, so x and y land exactly on ur. The block performs no clamping.
- Single-sample box (ll == ur): exactly one valid cycle. halt_RnnnnL is 1 during that cycle.
- Reset mid-walk: immediate return to WAIT_STATE, validSamp_R14H = 0, no further samples from that triangle.
- Sample count per triangle = ((ur.x − ll.x)/step + 1) · ((ur.y − ll.y)/step + 1).

Optional Feature:
- Macro: SAMPLE_ITER_COUNT_EN.
- When defined:
  - adds output port sampCount_R14U, 32 bits
  - holds the 1-based index of the current sample within its triangle
  - reloads to 1 on each accept and increments on each subsequent valid sample
  - resets to 0; 0 while validSamp_R14H = 0
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- 1 spp (subSample 4'b1000, step 1024), box ll=(0,0), ur=(2048,1024) -> samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles. halt_RnnnnL is 0 for the first 5 cycles and 1 on the 6th.
- 64 spp (4'b0001, step 128), box ll=(1024,1024), ur=(1152,1024) -> exactly 2 samples, (1024,1024) then (1152,1024).
- Back-to-back: triangle B valid while A emits its last sample -> B's first sample on the very next cycle, no validSamp_R14H bubble. tri_R14S switches to B on that cycle.
- Degenerate boxes:
  - ll=ur=(512,512) -> one valid cycle
  - ll=(1024,0), ur=(0,0) -> zero valid cycles; halt_RnnnnL stays 1
- Reset after the 3rd sample of a 16-sample box -> validSamp_R14H = 0 and halt_RnnnnL = 1 immediately (asynchronous). No samples after reset deasserts until a new triangle arrives.
- With SAMPLE_ITER_COUNT_EN, the 6-sample box above -> sampCount_R14U = 1..6 on the valid cycles, then 0.
